arm_run_controller: RTL and testbench

//   Parametrised simulation/bring-up run controller for the ARM core. Replaces fixed
//   "reset for one period, stop after N ns" bench control with cycle-exact sequencing:

---
 rtl/arm_sim_pkg.sv | 16 +
 rtl/arm_run_controller_if.sv | 33 +++
 rtl/arm_sat_counter.sv | 20 ++
 rtl/arm_run_controller.sv | 119 +++++++++++
 tb/tb_arm_run_controller.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/arm_sim_pkg.sv
// Shared definitions for the ARM simulation/bring-up run controller.
// Holds the FSM state encoding and the stat-select slot that exposes last_pc.
package arm_sim_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_t;

  // The last_pc slot sits directly after the event-counter channels.
  function automatic int last_pc_slot(input int num_ch);
    return num_ch;
  endfunction

endpackage

// File: rtl/arm_run_controller_if.sv
// Control/observation bundle between the bench (or board) and the run controller.
// master drives core observations and run controls; slave is the controller side.
interface arm_run_controller_if #(
  parameter int CNT_W  = 32,
  parameter int PC_W   = 32,
  parameter int NUM_CH = 4
);
  localparam int SEL_W = $clog2(NUM_CH + 1);

  logic              step_mode;
  logic              step_req;
  logic [PC_W-1:0]   pc;
  logic              pc_valid;
  logic [NUM_CH-1:0] evt;
  logic [SEL_W-1:0]  sel;
  logic              cpu_rst;
  logic              cpu_en;
  logic              done;
  logic              timeout;
  logic              halted;
  logic [CNT_W-1:0]  cycles;
  logic [CNT_W-1:0]  stat;

  modport master (
    output step_mode, step_req, pc, pc_valid, evt, sel,
    input  cpu_rst, cpu_en, done, timeout, halted, cycles, stat
  );

  modport slave (
    input  step_mode, step_req, pc, pc_valid, evt, sel,
    output cpu_rst, cpu_en, done, timeout, halted, cycles, stat
  );
endinterface

// File: rtl/arm_sat_counter.sv
// Saturating up-counter with synchronous clear; used for per-channel event counts.
module arm_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/arm_run_controller.sv
// Cycle-exact run controller for the ARM core: stretched core reset, free-run or
// single-step enable, timeout, branch-to-self halt detection and event counters.
module arm_run_controller
  import arm_sim_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int PC_W        = 32,
  parameter int RST_CYCLES  = 4,
  parameter int MAX_CYCLES  = 20,
  parameter int HALT_REPEAT = 3,
  parameter int NUM_CH      = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 rst,
  arm_run_controller_if.slave  bus
);

  localparam int SEL_W  = $clog2(NUM_CH + 1);
  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int REP_W  = $clog2(HALT_REPEAT + 1);

  run_state_t        state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [REP_W-1:0]  rep_cnt;
  logic [PC_W-1:0]   last_pc;
  logic              step_q;
  logic              cpu_rst_r, cpu_en_r, done_r, timeout_r, halted_r;
  logic [CNT_W-1:0]  cycles_r;
  logic [CNT_W-1:0]  ev_cnt [NUM_CH];

  logic              step_rise, run_en, hit_timeout, hit_halt;
  logic [CNT_W-1:0]  cycles_nxt;
  logic [REP_W-1:0]  rep_nxt;

  assign step_rise   = bus.step_req & ~step_q;
  assign run_en      = bus.step_mode ? step_rise : 1'b1;
  assign cycles_nxt  = cycles_r + 1'b1;
  assign hit_timeout = (cycles_nxt == CNT_W'(MAX_CYCLES));
  assign rep_nxt     = (bus.pc == last_pc) ? rep_cnt + 1'b1 : REP_W'(1);
  assign hit_halt    = bus.pc_valid && (rep_nxt == REP_W'(HALT_REPEAT));

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      rep_cnt   <= '0;
      last_pc   <= '0;
      step_q    <= 1'b0;
      cpu_rst_r <= 1'b1;
      cpu_en_r  <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      halted_r  <= 1'b0;
      cycles_r  <= '0;
    end else begin
      step_q <= bus.step_req;
      unique case (state)
        ST_HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_W'(RST_CYCLES - 1)) begin
            state     <= ST_RUN;
            cpu_rst_r <= 1'b0;
            cpu_en_r  <= run_en;
          end
        end
        ST_RUN: begin
          if (cpu_en_r) begin
            cycles_r <= cycles_nxt;
            if (bus.pc_valid) begin
              last_pc <= bus.pc;
              rep_cnt <= rep_nxt;
            end
            // Both terminations may land on the same edge; record each cause.
            if (hit_timeout || hit_halt) begin
              state     <= ST_DONE;
              cpu_en_r  <= 1'b0;
              done_r    <= 1'b1;
              timeout_r <= hit_timeout;
              halted_r  <= hit_halt;
            end else begin
              cpu_en_r <= run_en;
            end
          end else begin
            cpu_en_r <= run_en;
          end
        end
        ST_DONE: cpu_en_r <= 1'b0;
        default: state <= ST_HOLD;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_evt
    arm_sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (CLOCK_50),
      .clr   (rst),
      .en    (bus.evt[i] & cpu_en_r),
      .count (ev_cnt[i])
    );
  end

  // NOTE: every variable written in always_comb gets a default first so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    bus.stat = '0;
    for (int i = 0; i < NUM_CH; i++)
      if (bus.sel == SEL_W'(i)) bus.stat = ev_cnt[i];
    if (bus.sel == SEL_W'(last_pc_slot(NUM_CH)))
      bus.stat = CNT_W'(last_pc);
  end

  assign bus.cpu_rst = cpu_rst_r;
  assign bus.cpu_en  = cpu_en_r;
  assign bus.done    = done_r;
  assign bus.timeout = timeout_r;
  assign bus.halted  = halted_r;
  assign bus.cycles  = cycles_r;

endmodule

// File: tb/tb_arm_run_controller.sv
// Directed bench for arm_run_controller: a vector table for reset/hold/free-run
// timeout, plus hand sequences for halt, single-step, 4-bit counters and mid-run reset.
module tb_arm_run_controller;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  arm_run_controller_if #(.CNT_W(32), .PC_W(32), .NUM_CH(4)) bus_a ();
  arm_run_controller_if #(.CNT_W(4),  .PC_W(32), .NUM_CH(4)) bus_b ();

  arm_run_controller #(
    .CNT_W(32), .PC_W(32), .RST_CYCLES(4), .MAX_CYCLES(20), .HALT_REPEAT(3), .NUM_CH(4)
  ) dut_a (
    .CLOCK_50 (clk),
    .rst      (rst_a),
    .bus      (bus_a)
  );

  arm_run_controller #(
    .CNT_W(4), .PC_W(32), .RST_CYCLES(4), .MAX_CYCLES(15), .HALT_REPEAT(3), .NUM_CH(4)
  ) dut_b (
    .CLOCK_50 (clk),
    .rst      (rst_b),
    .bus      (bus_b)
  );

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        cpu_rst;
    logic        cpu_en;
    logic        done;
    logic        timeout;
    logic        halted;
    logic [31:0] cycles;
    logic [31:0] stat;
  } vec_t;

  vec_t vec [28];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a;
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.step_mode = 1'b0; bus_a.step_req = 1'b0; bus_a.pc = '0;
    bus_a.pc_valid  = 1'b1; bus_a.evt = '0;       bus_a.sel = 3'd4;
    bus_b.step_mode = 1'b0; bus_b.step_req = 1'b0; bus_b.pc = '0;
    bus_b.pc_valid  = 1'b0; bus_b.evt = 4'b0100;  bus_b.sel = 3'd2;

    // Reset for two edges, four hold edges, 20 free-run edges to timeout, 2 frozen edges.
    for (int i = 0; i < 28; i++) begin
      vec[i] = '{rst: 1'b0, pc: 32'h0, cpu_rst: 1'b0, cpu_en: 1'b0, done: 1'b0,
                 timeout: 1'b0, halted: 1'b0, cycles: 32'd0, stat: 32'd0};
      if (i < 2) begin
        vec[i].rst = 1'b1; vec[i].cpu_rst = 1'b1;
      end else if (i < 5) begin
        vec[i].cpu_rst = 1'b1;
      end else if (i == 5) begin
        vec[i].cpu_en = 1'b1;
      end else if (i < 26) begin
        vec[i].pc      = 32'(4 * (i - 6));
        vec[i].cycles  = 32'(i - 5);
        vec[i].stat    = 32'(4 * (i - 6));
        vec[i].cpu_en  = (i < 25);
        vec[i].done    = (i == 25);
        vec[i].timeout = (i == 25);
      end else begin
        vec[i].pc = 32'h999; vec[i].cycles = 32'd20; vec[i].stat = 32'd76;
        vec[i].done = 1'b1;  vec[i].timeout = 1'b1;
      end
    end

    for (int i = 0; i < 28; i++) begin
      rst_a    = vec[i].rst;
      bus_a.pc = vec[i].pc;
      tick();
      check($sformatf("v%0d cpu_rst", i), bus_a.cpu_rst, vec[i].cpu_rst);
      check($sformatf("v%0d cpu_en",  i), bus_a.cpu_en,  vec[i].cpu_en);
      check($sformatf("v%0d done",    i), bus_a.done,    vec[i].done);
      check($sformatf("v%0d timeout", i), bus_a.timeout, vec[i].timeout);
      check($sformatf("v%0d halted",  i), bus_a.halted,  vec[i].halted);
      check($sformatf("v%0d cycles",  i), bus_a.cycles,  vec[i].cycles);
      check($sformatf("v%0d stat",    i), bus_a.stat,    vec[i].stat);
    end

    // Halt: PC 0x40 held from the 5th enabled cycle, halt on its 3rd sample.
    bus_a.pc = '0;
    reset_a();
    repeat (4) tick();
    check("halt run_entered", bus_a.cpu_en, 1'b1);
    for (int r = 1; r <= 7; r++) begin
      bus_a.pc = (r < 5) ? 32'(4 * (r - 1)) : 32'h40;
      tick();
      if (r == 6) check("halt not_yet", bus_a.halted, 1'b0);
    end
    check("halt halted",  bus_a.halted,  1'b1);
    check("halt done",    bus_a.done,    1'b1);
    check("halt timeout", bus_a.timeout, 1'b0);
    check("halt cycles",  bus_a.cycles,  32'd7);
    check("halt cpu_en",  bus_a.cpu_en,  1'b0);
    check("halt stat_pc", bus_a.stat,    32'h40);
    tick();
    check("halt frozen_cycles", bus_a.cycles, 32'd7);

    // Single step: three rising edges, the second held five cycles.
    begin
      logic pat [15] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      logic prev;
      int   pulses;
      prev = 1'b0;
      pulses = 0;
      bus_a.step_mode = 1'b1;
      bus_a.step_req  = 1'b0;
      bus_a.pc_valid  = 1'b0;
      reset_a();
      repeat (4) tick();
      check("step idle_en", bus_a.cpu_en, 1'b0);
      for (int i = 0; i < 15; i++) begin
        bus_a.step_req = pat[i];
        tick();
        check($sformatf("step e%0d cpu_en", i), bus_a.cpu_en, pat[i] & ~prev);
        if (bus_a.cpu_en) pulses++;
        prev = pat[i];
      end
      check("step pulses",  32'(pulses),   32'd3);
      check("step cycles",  bus_a.cycles,  32'd3);
      check("step timeout", bus_a.timeout, 1'b0);
      check("step done",    bus_a.done,    1'b0);
    end

    // Mid-run reset at cycles=9, then the whole sequence repeats to timeout.
    bus_a.step_mode = 1'b0;
    bus_a.step_req  = 1'b0;
    bus_a.pc_valid  = 1'b1;
    bus_a.evt       = 4'b0010;
    bus_a.sel       = 3'd1;
    reset_a();
    repeat (4) tick();
    for (int r = 1; r <= 9; r++) begin
      bus_a.pc = 32'(4 * r);
      tick();
    end
    check("mid cycles_before", bus_a.cycles, 32'd9);
    check("mid evt1_before",   bus_a.stat,   32'd9);
    reset_a();
    check("mid cpu_rst", bus_a.cpu_rst, 1'b1);
    check("mid cpu_en",  bus_a.cpu_en,  1'b0);
    check("mid cycles",  bus_a.cycles,  32'd0);
    check("mid done",    bus_a.done,    1'b0);
    check("mid evt1",    bus_a.stat,    32'd0);
    bus_a.sel = 3'd4;
    #1;
    check("mid last_pc", bus_a.stat, 32'd0);
    for (int h = 1; h <= 4; h++) begin
      tick();
      check($sformatf("mid hold%0d cpu_rst", h), bus_a.cpu_rst, (h < 4));
      check($sformatf("mid hold%0d cpu_en",  h), bus_a.cpu_en,  (h == 4));
    end
    for (int r = 0; r < 40 && !bus_a.done; r++) begin
      bus_a.pc = 32'(4 * r + 8);
      tick();
    end
    check("mid2 done",    bus_a.done,    1'b1);
    check("mid2 timeout", bus_a.timeout, 1'b1);
    check("mid2 cycles",  bus_a.cycles,  32'd20);
    bus_a.sel = 3'd1;
    #1;
    check("mid2 evt1", bus_a.stat, 32'd20);

    // 4-bit counters: channel 2 counts every enabled cycle up to 15 without wrapping.
    rst_b = 1'b0;
    for (int r = 0; r < 60 && !bus_b.done; r++) tick();
    check("cnt4 done",    bus_b.done,    1'b1);
    check("cnt4 timeout", bus_b.timeout, 1'b1);
    check("cnt4 halted",  bus_b.halted,  1'b0);
    check("cnt4 cycles",  bus_b.cycles,  4'd15);
    check("cnt4 evt2",    bus_b.stat,    4'd15);
    tick();
    check("cnt4 evt2_frozen", bus_b.stat, 4'd15);
    bus_b.sel = 3'd5;
    #1;
    check("cnt4 sel_out_of_range", bus_b.stat, 4'd0);
    bus_b.sel = 3'd0;
    #1;
    check("cnt4 evt0", bus_b.stat, 4'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
